// File: rtl/access_pkg.sv
// Shared definitions for the password-gated access controller: FSM state
// encodings, default sizing constants and a counter-width helper.
package access_pkg;

    typedef enum logic [2:0] {
        ST_RESET   = 3'b000,
        ST_ACTIVE  = 3'b001,
        ST_LOCKOUT = 3'b010,
        ST_REQUEST = 3'b101,
        ST_SAVE    = 3'b110,
        ST_TRAP    = 3'b111
    } state_e;

    localparam int DEF_PW_W           = 3;
    localparam int DEF_DATA_W         = 7;
    localparam int DEF_N_CH           = 2;
    localparam int DEF_MAX_TRIES      = 3;
    localparam int DEF_LOCK_CYCLES    = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Width of a down/up counter that must hold values 0..n-1 (never below 1).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/access_ctrl_multi_edge_det.sv
// Registered rising-edge detector for front-panel level inputs. The pulse is
// combinational from the live input, so it acts on the same clock edge.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q, d_d;

    always_comb begin
        d_d = d;
    end

    always_ff @(posedge clk) begin
        if (!rst) d_q <= 1'b0;
        else      d_q <= d_d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/access_ctrl_multi.sv
// Password-gated access controller routing payload words into N_CH channels,
// with retry lockout, trap, and multi-write sessions. Define ACCESS_TIMEOUT_EN
// to end idle sessions after TIMEOUT_CYCLES cycles in REQUEST.
module access_ctrl_multi
    import access_pkg::*;
#(
    parameter int               PW_W           = DEF_PW_W,
    parameter logic [PW_W-1:0]  PASSWORD       = {PW_W{1'b1}},
    parameter int               DATA_W         = DEF_DATA_W,
    parameter int               N_CH           = DEF_N_CH,
    parameter int               CH_W           = $clog2(N_CH),
    parameter int               MAX_TRIES      = DEF_MAX_TRIES,
    parameter int               LOCK_CYCLES    = DEF_LOCK_CYCLES,
    parameter int               TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              confirm,
    input  logic              logout,
    input  logic [PW_W-1:0]   password,
    input  logic [CH_W-1:0]   sel,
    input  logic [DATA_W-1:0] data,
    output logic [N_CH-1:0]   en,
    output logic [DATA_W-1:0] dout,
    output logic [2:0]        state,
    output logic [2:0]        tries_left,
    output logic              sel_err
);

    localparam int            LOCK_W   = cnt_w(LOCK_CYCLES);
    localparam logic [CH_W:0] N_CH_V   = (CH_W+1)'(N_CH);
    localparam logic [2:0]    TRIES_MX = 3'(MAX_TRIES);

    if (N_CH < 2 || MAX_TRIES < 1 || MAX_TRIES > 7 || LOCK_CYCLES < 1 ||
        TIMEOUT_CYCLES < 2) begin : g_param_chk
        $error("access_ctrl_multi: illegal parameter set");
    end

    logic cpulse;

    edge_det u_confirm_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (confirm),
        .pulse (cpulse)
    );

    state_e              state_q, state_d;
    logic [2:0]          tries_q, tries_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [CH_W-1:0]     chsel_q, chsel_d;
    logic [N_CH-1:0]     en_q, en_d;
    logic                sel_err_q, sel_err_d;
    logic                sel_ok;

`ifdef ACCESS_TIMEOUT_EN
    localparam int             TO_W    = cnt_w(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] idle_q, idle_d;
`endif

    assign sel_ok = ({1'b0, sel} < N_CH_V);

    always_comb begin
        state_d   = state_q;
        tries_d   = tries_q;
        lock_d    = lock_q;
        dout_d    = dout_q;
        chsel_d   = chsel_q;
        sel_err_d = 1'b0;
`ifdef ACCESS_TIMEOUT_EN
        // Idle count only survives while sitting in REQUEST with no confirm.
        idle_d    = '0;
`endif
        case (state_q)
            ST_RESET: state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (cpulse) begin
                    if (password == PASSWORD) begin
                        state_d = ST_REQUEST;
                        tries_d = TRIES_MX;
                    end else begin
                        tries_d = tries_q - 3'd1;
                        if (tries_q == 3'd1) begin
                            state_d = ST_TRAP;
                        end else begin
                            state_d = ST_LOCKOUT;
                            lock_d  = LOCK_W'(LOCK_CYCLES - 1);
                        end
                    end
                end
            end
            ST_LOCKOUT: begin
                if (lock_q == '0) state_d = ST_ACTIVE;
                else              lock_d  = lock_q - 1'b1;
            end
            ST_REQUEST: begin
                if (logout) begin
                    state_d = ST_ACTIVE;
                end else if (cpulse) begin
                    if (sel_ok) begin
                        state_d = ST_SAVE;
                        dout_d  = data;
                        chsel_d = sel;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
`ifdef ACCESS_TIMEOUT_EN
                else if (idle_q == TO_LAST) begin
                    state_d = ST_ACTIVE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
`endif
            end
            ST_SAVE:  state_d = ST_REQUEST;
            ST_TRAP:  state_d = ST_TRAP;
            default:  state_d = ST_RESET;
        endcase
        // Strobe is registered so it is high for exactly the SAVE cycle.
        en_d = (state_d == ST_SAVE) ? (N_CH'(1) << chsel_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_RESET;
            tries_q   <= TRIES_MX;
            lock_q    <= '0;
            dout_q    <= '0;
            chsel_q   <= '0;
            en_q      <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tries_q   <= tries_d;
            lock_q    <= lock_d;
            dout_q    <= dout_d;
            chsel_q   <= chsel_d;
            en_q      <= en_d;
            sel_err_q <= sel_err_d;
        end
    end

`ifdef ACCESS_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) idle_q <= '0;
        else      idle_q <= idle_d;
    end
`endif

    assign state      = state_q;
    assign tries_left = tries_q;
    assign en         = en_q;
    assign dout       = dout_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_access_ctrl_multi.sv
// Self-checking bench for access_ctrl_multi: directed scenarios plus a random
// run checked against a cycle-level behavioural model of the access rules.
module tb_access_ctrl_multi;

    localparam int PW_W = 3, DATA_W = 7, N_CH = 3, CH_W = 2;
    localparam int MAX_TRIES = 3, LOCK_CYCLES = 16, TIMEOUT_CYCLES = 8;
    localparam logic [2:0] S_RESET = 3'b000, S_ACTIVE = 3'b001, S_LOCK = 3'b010,
                           S_REQ = 3'b101, S_SAVE = 3'b110, S_TRAP = 3'b111;
    localparam logic [PW_W-1:0] GOOD_PW = 3'b111;

    logic clk = 1'b0;
    logic rst, confirm, logout;
    logic [PW_W-1:0]   password;
    logic [CH_W-1:0]   sel;
    logic [DATA_W-1:0] data;
    logic [N_CH-1:0]   en;
    logic [DATA_W-1:0] dout;
    logic [2:0]        state, tries_left;
    logic              sel_err;

    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    access_ctrl_multi #(
        .PW_W(PW_W), .DATA_W(DATA_W), .N_CH(N_CH), .MAX_TRIES(MAX_TRIES),
        .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .confirm(confirm), .logout(logout),
        .password(password), .sel(sel), .data(data), .en(en), .dout(dout),
        .state(state), .tries_left(tries_left), .sel_err(sel_err)
    );

    // Reference model: lock_left counts remaining lockout cycles, idle counts
    // elapsed idle cycles in a session; both follow the rules, not the RTL.
    logic [2:0]        m_state = S_RESET;
    int                m_tries = MAX_TRIES, lock_left = 0, idle = 0;
    logic [N_CH-1:0]   m_en = '0;
    logic [DATA_W-1:0] m_dout = '0;
    logic              m_selerr = 1'b0;
    bit                prev_conf = 1'b0;

    task automatic tick();
        bit press;
        @(posedge clk);
        press = confirm && !prev_conf;
        if (!rst) begin
            m_state = S_RESET; m_tries = MAX_TRIES; lock_left = 0; idle = 0;
            m_en = '0; m_dout = '0; m_selerr = 1'b0; prev_conf = 1'b0;
        end else begin
            prev_conf = confirm;
            m_en = '0;
            m_selerr = 1'b0;
            case (m_state)
                S_RESET: m_state = S_ACTIVE;
                S_ACTIVE: if (press) begin
                    if (password == GOOD_PW) begin
                        m_state = S_REQ; m_tries = MAX_TRIES; idle = 0;
                    end else begin
                        m_tries = m_tries - 1;
                        if (m_tries == 0) m_state = S_TRAP;
                        else begin m_state = S_LOCK; lock_left = LOCK_CYCLES; end
                    end
                end
                S_LOCK: begin
                    lock_left = lock_left - 1;
                    if (lock_left == 0) m_state = S_ACTIVE;
                end
                S_REQ: begin
                    if (logout) m_state = S_ACTIVE;
                    else if (press) begin
                        idle = 0;
                        if (int'(sel) < N_CH) begin
                            m_state = S_SAVE; m_dout = data;
                            m_en = N_CH'(1) << sel;
                        end else m_selerr = 1'b1;
                    end else begin
`ifdef ACCESS_TIMEOUT_EN
                        idle = idle + 1;
                        if (idle == TIMEOUT_CYCLES) m_state = S_ACTIVE;
`endif
                    end
                end
                S_SAVE: begin m_state = S_REQ; idle = 0; end
                default: m_state = m_state;
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; confirm = 0; logout = 0; password = '0; sel = '0; data = '0;
        tick(); tick();
        checks++; if (state !== S_RESET) begin fails++; $display("FAIL reset_state: got %b want %b", state, S_RESET); end
        checks++; if (en !== 3'b000) begin fails++; $display("FAIL reset_en: got %b want 000", en); end
        checks++; if (dout !== 7'h00) begin fails++; $display("FAIL reset_dout: got %h want 00", dout); end
        checks++; if (tries_left !== 3'd3) begin fails++; $display("FAIL reset_tries: got %0d want 3", tries_left); end
        checks++; if (sel_err !== 1'b0) begin fails++; $display("FAIL reset_sel_err: got %b want 0", sel_err); end
        rst = 1'b1; tick();
        checks++; if (state !== S_ACTIVE) begin fails++; $display("FAIL reset_to_active: got %b want %b", state, S_ACTIVE); end
    endtask

    task automatic test_login_write();
        password = GOOD_PW; confirm = 1; tick();
        checks++; if (state !== S_REQ) begin fails++; $display("FAIL login_state: got %b want %b", state, S_REQ); end
        confirm = 0; tick();
        sel = 2'd1; data = 7'h5A; confirm = 1; tick();
        checks++; if (state !== S_SAVE) begin fails++; $display("FAIL write_state: got %b want %b", state, S_SAVE); end
        checks++; if (en !== 3'b010) begin fails++; $display("FAIL write_en: got %b want 010", en); end
        checks++; if (dout !== 7'h5A) begin fails++; $display("FAIL write_dout: got %h want 5a", dout); end
        confirm = 0; tick();
        checks++; if (state !== S_REQ || en !== 3'b000) begin fails++; $display("FAIL write_after: got state %b en %b want 101 000", state, en); end
        checks++; if (dout !== 7'h5A) begin fails++; $display("FAIL write_dout_hold: got %h want 5a", dout); end
    endtask

    task automatic test_held_confirm();
        int pulses = 0;
        sel = 2'd2; data = 7'h33; confirm = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (en !== 3'b000) pulses++;
        end
        confirm = 0; tick();
        checks++; if (pulses != 1) begin fails++; $display("FAIL held_confirm_pulses: got %0d want 1", pulses); end
        checks++; if (dout !== 7'h33) begin fails++; $display("FAIL held_confirm_dout: got %h want 33", dout); end
    endtask

    task automatic test_invalid_sel();
        sel = 2'd3; data = 7'h11; confirm = 1; tick();
        checks++; if (sel_err !== 1'b1) begin fails++; $display("FAIL bad_sel_err: got %b want 1", sel_err); end
        checks++; if (state !== S_REQ || en !== 3'b000) begin fails++; $display("FAIL bad_sel_state: got state %b en %b want 101 000", state, en); end
        checks++; if (dout !== 7'h33) begin fails++; $display("FAIL bad_sel_dout: got %h want 33", dout); end
        confirm = 0; tick();
        checks++; if (sel_err !== 1'b0) begin fails++; $display("FAIL bad_sel_pulse_width: got %b want 0", sel_err); end
    endtask

    task automatic test_logout_priority();
        sel = 2'd0; logout = 1; confirm = 1; tick();
        checks++; if (state !== S_ACTIVE || en !== 3'b000) begin fails++; $display("FAIL logout_priority: got state %b en %b want 001 000", state, en); end
        logout = 0; confirm = 0; tick();
    endtask

    task automatic test_reset_mid_save();
        password = GOOD_PW; confirm = 1; tick();
        confirm = 0; tick();
        sel = 2'd0; data = 7'h6C; confirm = 1; tick();
        checks++; if (state !== S_SAVE || en !== 3'b001) begin fails++; $display("FAIL pre_reset_save: got state %b en %b want 110 001", state, en); end
        rst = 0; tick();
        checks++; if (state !== S_RESET || en !== 3'b000 || dout !== 7'h00) begin fails++; $display("FAIL reset_mid_save: got state %b en %b dout %h want 000 000 00", state, en, dout); end
        rst = 1; confirm = 0; tick();
    endtask

    task automatic test_retry_trap();
        int n;
        password = 3'b010;
        for (int k = 1; k <= 2; k++) begin
            confirm = 1; tick();
            checks++; if (state !== S_LOCK || tries_left !== 3'(MAX_TRIES - k)) begin fails++; $display("FAIL lockout_entry%0d: got state %b tries %0d want 010 %0d", k, state, tries_left, MAX_TRIES - k); end
            confirm = 0; n = 0;
            while (state === S_LOCK && n < 40) begin
                n++;
                if (n == 5) begin confirm = 1; password = GOOD_PW; end
                if (n == 6) begin confirm = 0; password = 3'b010; end
                tick();
            end
            checks++; if (n != LOCK_CYCLES || state !== S_ACTIVE) begin fails++; $display("FAIL lockout_len%0d: got %0d cycles state %b want %0d 001", k, n, state, LOCK_CYCLES); end
        end
        confirm = 1; tick();
        checks++; if (state !== S_TRAP || tries_left !== 3'd0) begin fails++; $display("FAIL trap_entry: got state %b tries %0d want 111 0", state, tries_left); end
        confirm = 0; tick();
        password = GOOD_PW; confirm = 1; tick();
        checks++; if (state !== S_TRAP) begin fails++; $display("FAIL trap_sticky: got %b want 111", state); end
        confirm = 0; rst = 0; tick(); rst = 1; tick();
    endtask

`ifdef ACCESS_TIMEOUT_EN
    task automatic test_timeout();
        int n = 1;
        password = GOOD_PW; confirm = 1; tick();
        confirm = 0;
        while (state === S_REQ && n < 40) begin tick(); if (state === S_REQ) n++; end
        checks++; if (n != TIMEOUT_CYCLES || state !== S_ACTIVE) begin fails++; $display("FAIL timeout_len: got %0d cycles state %b want %0d 001", n, state, TIMEOUT_CYCLES); end
        confirm = 1; tick();
        confirm = 0;
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
        sel = 2'd2; data = 7'h2B; confirm = 1; tick();
        checks++; if (state !== S_SAVE || en !== 3'b100) begin fails++; $display("FAIL timeout_confirm_wins: got state %b en %b want 110 100", state, en); end
        confirm = 0; tick();
    endtask
`endif

    task automatic test_random();
        logic [15:0] got, exp;
        for (int i = 0; i < 800; i++) begin
            rst      = ($urandom_range(0, 59) != 0);
            confirm  = $urandom_range(0, 1);
            logout   = ($urandom_range(0, 11) == 0);
            password = ($urandom_range(0, 9) < 8) ? GOOD_PW : PW_W'($urandom);
            sel      = CH_W'($urandom);
            data     = DATA_W'($urandom);
            tick();
            got = {state, tries_left, en, dout};
            exp = {m_state, 3'(m_tries), m_en, m_dout};
            checks++;
            if (got !== exp || sel_err !== m_selerr) begin
                fails++;
                $display("FAIL random_cycle%0d: got st %b tr %0d en %b dout %h se %b want st %b tr %0d en %b dout %h se %b",
                         i, state, tries_left, en, dout, sel_err, m_state, m_tries, m_en, m_dout, m_selerr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_login_write();
        test_held_confirm();
        test_invalid_sel();
        test_logout_priority();
        test_reset_mid_save();
        test_retry_trap();
`ifdef ACCESS_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
